mcp3201_responder: RTL and testbench

MCP3201_RESPONDER -- requirements
Module: mcp3201_responder

---
 rtl/mcp3201_responder_pkg.sv | 34 +++
 rtl/sync_edge.sv | 30 +++
 rtl/mcp3201_responder.sv | 127 ++++++++++++
 tb/tb_mcp3201_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mcp3201_responder_pkg.sv
// Shared types and constants for the MCP3201 ADC responder.
// Also holds the frame bit-order helper used by the output stage.
package mcp3201_responder_pkg;

    localparam int ADC_BITS        = 12;
    localparam int FRAME_MSB_EDGES = 14;
    localparam int FRAME_LSB_LAST  = 2 * ADC_BITS + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_NULLB,
        ST_MSBF,
        ST_LSBF,
        ST_TAIL
    } state_t;

    // Bit driven after falling edge number e (1-based) of a frame.
    function automatic logic frame_bit(
        input logic [ADC_BITS-1:0] code,
        input logic [4:0]          e
    );
        logic b;
        b = 1'b0;
        if (e >= 5'd3 && e <= 5'(FRAME_MSB_EDGES)) begin
            b = code[4'(5'(FRAME_MSB_EDGES) - e)];
        end else if (e > 5'(FRAME_MSB_EDGES) &&
                     e <= 5'(FRAME_LSB_LAST)) begin
            b = code[4'(e - 5'(FRAME_MSB_EDGES))];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with one extra registered stage
// for rising/falling edge detection.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcp3201_responder.sv
// Emulates an MCP3201 12-bit SPI ADC towards an external master,
// serving codes from a one-word valid/ready holding register.
module mcp3201_responder
    import mcp3201_responder_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [ADC_BITS-1:0] IDLE_VALUE  = 12'h800
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                adc_ssn,
    input  logic                adc_clk,
    output logic                adc_dat,
    output logic                adc_dat_oe,
    input  logic [ADC_BITS-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                frame_strb,
    output logic                underrun
);

    localparam logic [2:0] SETTLED = 3'(SYNC_STAGES + 1);

    logic ssn_rise, ssn_fall;
    logic clk_rise, clk_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssn_sync (
        .clock (clock),
        .reset (reset),
        .d     (adc_ssn),
        .rise  (ssn_rise),
        .fall  (ssn_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clock (clock),
        .reset (reset),
        .d     (adc_clk),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    state_t              state_q;
    logic [4:0]          edge_cnt_q;
    logic [4:0]          edge_nxt;
    logic [ADC_BITS-1:0] hold_q;
    logic [ADC_BITS-1:0] shift_q;
    logic                fresh_q;
    logic                underrun_q;
    logic                dat_q;
    logic                oe_q;
    logic                strb_q;
    logic                clk_hi_q;
    logic [2:0]          settle_q;
    logic                xfer;
    logic                start;
    logic                sck_fall;

    // A low ssn at reset release propagates as a fake fall; blank it.
    assign start    = ssn_fall & (settle_q == SETTLED);
    assign xfer     = sample_valid & ~fresh_q;
    assign sck_fall = clk_fall & clk_hi_q;
    assign edge_nxt = (edge_cnt_q == 5'd31) ? 5'd31 : edge_cnt_q + 5'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            hold_q     <= IDLE_VALUE;
            shift_q    <= IDLE_VALUE;
            fresh_q    <= 1'b0;
            underrun_q <= 1'b0;
            dat_q      <= 1'b0;
            oe_q       <= 1'b0;
            strb_q     <= 1'b0;
            clk_hi_q   <= 1'b0;
            settle_q   <= '0;
        end else begin
            strb_q <= 1'b0;
            if (settle_q != SETTLED) settle_q <= settle_q + 3'd1;
            if (clk_rise)      clk_hi_q <= 1'b1;
            else if (clk_fall) clk_hi_q <= 1'b0;

            if (xfer) hold_q <= sample_data;
            if (start)     fresh_q <= xfer;
            else if (xfer) fresh_q <= 1'b1;
            if (start && !fresh_q) underrun_q <= 1'b1;

            if (ssn_rise) begin
                strb_q     <= (state_q != ST_IDLE) &&
                              (edge_cnt_q >= 5'(FRAME_MSB_EDGES));
                state_q    <= ST_IDLE;
                edge_cnt_q <= '0;
                dat_q      <= 1'b0;
                oe_q       <= 1'b0;
            end else if (start) begin
                state_q    <= ST_SAMPLE;
                shift_q    <= hold_q;
                edge_cnt_q <= '0;
                dat_q      <= 1'b0;
                oe_q       <= 1'b0;
            end else if (sck_fall && state_q != ST_IDLE) begin
                edge_cnt_q <= edge_nxt;
                dat_q      <= frame_bit(shift_q, edge_nxt);
                unique case (state_q)
                    ST_SAMPLE: if (edge_nxt == 5'd2) begin
                        state_q <= ST_NULLB;
                        oe_q    <= 1'b1;
                    end
                    ST_NULLB: state_q <= ST_MSBF;
                    ST_MSBF: if (edge_nxt == 5'(FRAME_MSB_EDGES + 1))
                        state_q <= ST_LSBF;
                    ST_LSBF: if (edge_nxt == 5'(FRAME_LSB_LAST + 1))
                        state_q <= ST_TAIL;
                    default: ;
                endcase
            end
        end
    end

    assign adc_dat      = dat_q;
    assign adc_dat_oe   = oe_q;
    assign frame_strb   = strb_q;
    assign underrun     = underrun_q;
    assign sample_ready = ~fresh_q;

endmodule

// File: tb/tb_mcp3201_responder.sv
// Directed bench: an SPI master model plays frames against the responder
// while a queue of expected {oe,dat} pairs is checked bit by bit.
module tb_mcp3201_responder;

    localparam int S    = 2;
    localparam int HALF = 8;

    logic        clock;
    logic        reset;
    logic        adc_ssn;
    logic        adc_clk;
    logic        adc_dat;
    logic        adc_dat_oe;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        frame_strb;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    int strb_cnt = 0;
    logic [1:0] sb[$];

    mcp3201_responder #(.SYNC_STAGES(S), .IDLE_VALUE(12'h800)) dut (
        .clock        (clock),
        .reset        (reset),
        .adc_ssn      (adc_ssn),
        .adc_clk      (adc_clk),
        .adc_dat      (adc_dat),
        .adc_dat_oe   (adc_dat_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_strb   (frame_strb),
        .underrun     (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (frame_strb) strb_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected serial bit after falling edge e of a frame carrying c.
    function automatic logic exp_bit(input logic [11:0] c, input int e);
        logic [11:0] v;
        v = c;
        if (e >= 3 && e <= 14) return v[4'(14 - e)];
        if (e >= 15 && e <= 25) return v[4'(e - 14)];
        return 1'b0;
    endfunction

    task automatic load(input logic [11:0] w);
        int n;
        n = 0;
        while (!sample_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_load", 16'(sample_ready), 16'd1);
        sample_data  = w;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        check("ready_after_load", 16'(sample_ready), 16'd0);
    endtask

    task automatic frame(input int nclk, input logic [11:0] code,
                         input logic exp_ur, input logic exp_rdy,
                         input logic coinc, input logic [11:0] cword);
        int s0;
        logic [1:0] e;
        for (int i = 1; i <= nclk; i++)
            sb.push_back({logic'(i >= 2), exp_bit(code, i)});
        s0 = strb_cnt;
        @(negedge clock);
        adc_ssn = 1'b0;
        if (coinc) begin
            repeat (S) @(negedge clock);
            sample_data  = cword;
            sample_valid = 1'b1;
            @(negedge clock);
            sample_valid = 1'b0;
            repeat (HALF - S - 1) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        check("underrun_at_start", 16'(underrun), 16'(exp_ur));
        check("ready_at_start", 16'(sample_ready), 16'(exp_rdy));
        for (int i = 1; i <= nclk; i++) begin
            adc_clk = 1'b1;
            repeat (HALF) @(negedge clock);
            adc_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            if (sb.size() == 0) begin
                check("sb_underflow", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("edge%0d_oe_dat", i),
                      16'({adc_dat_oe, adc_dat}), 16'(e));
            end
        end
        adc_ssn = 1'b1;
        repeat (S + 2) @(negedge clock);
        check("oe_after_ssn_rise", 16'(adc_dat_oe), 16'd0);
        check("dat_after_ssn_rise", 16'(adc_dat), 16'd0);
        repeat (4) @(negedge clock);
        check("strobe_count", 16'(strb_cnt - s0), 16'(nclk >= 14));
    endtask

    initial begin
        reset        = 1'b0;
        adc_ssn      = 1'b1;
        adc_clk      = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_oe", 16'(adc_dat_oe), 16'd0);
        check("rst_dat", 16'(adc_dat), 16'd0);
        check("rst_strb", 16'(frame_strb), 16'd0);
        check("rst_underrun", 16'(underrun), 16'd0);
        check("rst_ready", 16'(sample_ready), 16'd1);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        load(12'hA5C);
        frame(16, 12'hA5C, 1'b0, 1'b1, 1'b0, 12'h0);

        load(12'h3C1);
        frame(26, 12'h3C1, 1'b0, 1'b1, 1'b0, 12'h0);

        frame(16, 12'h3C1, 1'b1, 1'b1, 1'b0, 12'h0);
        repeat (10) @(negedge clock);
        check("underrun_sticky", 16'(underrun), 16'd1);

        load(12'h5A3);
        frame(6, 12'h5A3, 1'b1, 1'b1, 1'b0, 12'h0);
        load(12'h123);
        frame(16, 12'h123, 1'b1, 1'b1, 1'b0, 12'h0);

        frame(40, 12'h123, 1'b1, 1'b0, 1'b1, 12'h777);
        frame(16, 12'h777, 1'b1, 1'b1, 1'b0, 12'h0);

        load(12'h456);
        @(negedge clock);
        adc_ssn = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 1; i <= 9; i++) begin
            adc_clk = 1'b1;
            repeat (HALF) @(negedge clock);
            adc_clk = 1'b0;
            repeat (HALF) @(negedge clock);
        end
        check("midframe_oe", 16'(adc_dat_oe), 16'd1);
        reset = 1'b0;
        #1;
        check("async_rst_oe", 16'(adc_dat_oe), 16'd0);
        check("async_rst_dat", 16'(adc_dat), 16'd0);
        check("async_rst_strb", 16'(frame_strb), 16'd0);
        check("async_rst_underrun", 16'(underrun), 16'd0);
        check("async_rst_ready", 16'(sample_ready), 16'd1);
        adc_ssn = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        frame(16, 12'h800, 1'b1, 1'b1, 1'b0, 12'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
